load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage sitting directly downstream of the datapath: it takes the datapath's memory address, store data and load/store request, and drives a variable-latency data bus with a request/response handshake. It returns load data on the datapath's `read_data` input. It stalls the core until the access completes, and performs byte-lane steering for byte loads/stores. Misaligned word accesses and, optionally, bus timeouts are reported as a fault.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255 — cycles spent in REQ+RESP before abort (used only with timeout compiled in)

Ports:
- `clk`  in  1  — single clock, all state on rising edge
- `reset`  in  1  — synchronous, active-high
- `mem_read`  in  1  — core load request; held stable while `stall`=1
- `mem_write`  in  1  — core store request; held stable while `stall`=1
- `byte_access`  in  1  — 1 = byte access (LDRB/STRB), 0 = word
- `addr`  in  32  — from datapath `data_memory_addr`
- `wdata`  in  32  — from datapath `write_data`
- `rdata`  out  32  — to datapath `read_data`; registered
- `stall`  out  1  — hold core (PC and register writes)
- `fault`  out  1  — one-cycle pulse in DONE on misalign/timeout
- `bus_valid`  out  1  — request valid
- `bus_ready`  in  1  — request accepted
- `bus_we`  out  1  — 1 = write
- `bus_addr`  out  32  — word-aligned (`addr[31:2]`,2'b00)
- `bus_wdata`  out  32
- `bus_be`  out  4  — byte enables
- `resp_valid`  in  1  — response/ack (reads and writes)
- `resp_rdata`  in  32

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Reset: IDLE; `rdata`=0, `bus_valid`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_be`=0, `fault`=0.
- IDLE: on `mem_read|mem_write`, latch addr/wdata/size/dir and go to REQ. Exception: a misaligned word access (`!byte_access && addr[1:0]!=0`) goes to DONE with `fault`=1, `rdata`=0, no bus activity.
- `mem_read` and `mem_write` both high: write wins, read ignored.
- REQ: `bus_valid`=1, bus fields stable; on `bus_ready` → RESP.
- RESP: on `resp_valid` → DONE. For reads, capture the result into `rdata`:
  - word: `resp_rdata`
  - byte: lane `addr[1:0]`, zero-extended to 32
- DONE: one cycle, `stall`=0, `rdata` valid; then → IDLE unconditionally.
- Stores:
  - word: `bus_be`=4'hF, `bus_wdata`=`wdata`
  - byte: `bus_be`=1<<`addr[1:0]`, `bus_wdata`=`wdata[7:0]` replicated ×4
- `stall` = (IDLE && request) || REQ || RESP; combinational. It is low in DONE and in IDLE with no request.
- `resp_valid` outside RESP is ignored, including stale responses after reset.
- Reset mid-transaction: next edge IDLE, `bus_valid`=0; the outstanding request is abandoned.

## Timing
- Zero-wait bus (`bus_ready` in first REQ cycle, `resp_valid` in first RESP cycle):
  - cycle 0 IDLE sees request
  - cycle 1 REQ
  - cycle 2 RESP
  - cycle 3 DONE
  - `stall` high cycles 0–2; `rdata` valid cycle 3
- Each wait cycle on `bus_ready` or `resp_valid` adds one stall cycle.
- Misaligned access: stall cycle 0 only, DONE cycle 1 with `fault`=1.
- Back-to-back accesses: a new request is seen in the IDLE cycle after DONE. Minimum 4 cycles per access.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - 8-bit+ counter cleared on entering REQ, increments in REQ/RESP.
  - At `TIMEOUT_CYCLES`: drop `bus_valid`, go to DONE with `fault`=1, `rdata`=0.
- Undefined: no counter; REQ/RESP wait indefinitely; `fault` only from misalignment.

## Structure
- Package `lsu_pkg`: state enum (IDLE/REQ/RESP/DONE), size encoding constants, byte-enable function `lane_mask(size, addr[1:0])`.
- One combinational sub-module `lsu_lane_align`: store replication/byte-enable generation and load lane extract/zero-extend. The FSM, latches and timeout counter live in `load_store_unit`.

## Test plan
- Word load addr 0x100, `resp_rdata`=0xDEADBEEF, zero-wait → `stall` high 3 cycles, `rdata`=0xDEADBEEF in DONE, `bus_be`=4'hF, `bus_we`=0.
- Byte store addr 0x103, `wdata`=0x12345678 → `bus_addr`=0x100, `bus_be`=4'b1000, `bus_wdata`=0x78787878, `bus_we`=1.
- Byte load addr 0x202, `resp_rdata`=0xAABBCCDD, `bus_ready` delayed 2 cycles → `rdata`=0x000000BB, stall 5 cycles.
- Word load addr 0x101 → no `bus_valid`, `fault` pulse cycle 1, `rdata`=0.
- With `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `bus_ready` never asserted → `bus_valid` drops and `fault`=1 after 16 cycles. Without the macro, still stalled at cycle 100.
- `reset` asserted in RESP, then `resp_valid` pulses in IDLE → state IDLE, `rdata` stays 0, `stall`=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, size encoding and byte-lane mask for the load/store unit
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   localparam logic SIZE_WORD = 1'b0;
   localparam logic SIZE_BYTE = 1'b1;

   function automatic logic [3:0] lane_mask(input logic size, input logic [1:0] lane);
      if (size == SIZE_BYTE) begin
         return 4'b0001 << lane;
      end
      return 4'hF;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering for stores and lane extract/zero-extend for loads
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic        size,
   input  logic [1:0]  lane,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be,
   output logic [31:0] store_word,
   output logic [31:0] load_data
);

   assign be = lane_mask(size, lane);

   // byte stores put the low byte on every lane so the enables alone pick the target
   assign store_word = (size == SIZE_BYTE) ? {4{store_data[7:0]}} : store_data;

   assign load_data = (size == SIZE_BYTE) ? {24'h0, load_word[{lane, 3'b000} +: 8]} : load_word;

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory access stage: request/response bus FSM, stall and fault
// Optional bus timeout compiled in with LSU_TIMEOUT_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        byte_access,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        fault,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        resp_valid,
   input  logic [31:0] resp_rdata
);

   lsu_state_t  state, state_next;
   logic        req;
   logic        misaligned;
   logic        latch_req;
   logic        set_fault;
   logic        capture_load;
   logic        tmo_hit;
   logic        byte_q;
   logic [1:0]  lane_q;
   logic        sel_size;
   logic [1:0]  sel_lane;
   logic [3:0]  lane_be;
   logic [31:0] lane_store;
   logic [31:0] lane_load;

   assign req        = mem_read | mem_write;
   assign misaligned = !byte_access && (addr[1:0] != 2'b00);

   // store steering needs the live request in IDLE; load extraction needs the latched one in RESP
   assign sel_size = (state == IDLE) ? byte_access : byte_q;
   assign sel_lane = (state == IDLE) ? addr[1:0]   : lane_q;

   lsu_lane_align u_lane_align (
      .size       (sel_size),
      .lane       (sel_lane),
      .store_data (wdata),
      .load_word  (resp_rdata),
      .be         (lane_be),
      .store_word (lane_store),
      .load_data  (lane_load)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (reset || state == IDLE) begin
         tmo_cnt <= '0;
      end else if (state == REQ || state == RESP) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign tmo_hit = (state == REQ || state == RESP) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign tmo_hit        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      latch_req    = 1'b0;
      set_fault    = 1'b0;
      capture_load = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (misaligned) begin
                  state_next = DONE;
                  set_fault  = 1'b1;
               end else begin
                  state_next = REQ;
                  latch_req  = 1'b1;
               end
            end
         end
         REQ: begin
            if (bus_ready) begin
               state_next = RESP;
            end else if (tmo_hit) begin
               state_next = DONE;
               set_fault  = 1'b1;
            end
         end
         RESP: begin
            if (resp_valid) begin
               state_next   = DONE;
               capture_load = !bus_we;
            end else if (tmo_hit) begin
               state_next = DONE;
               set_fault  = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign stall     = ((state == IDLE) && req) || (state == REQ) || (state == RESP);
   assign bus_valid = (state == REQ);

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata     <= '0;
         fault     <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= '0;
         byte_q    <= 1'b0;
         lane_q    <= 2'b00;
      end else begin
         fault <= set_fault;
         if (set_fault) begin
            rdata <= '0;
         end else if (capture_load) begin
            rdata <= lane_load;
         end
         // write wins when both requests are raised
         if (latch_req) begin
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= lane_store;
            bus_be    <= lane_be;
            byte_q    <= byte_access;
            lane_q    <= addr[1:0];
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write, byte_access;
   logic [31:0] addr, wdata, rdata;
   logic        stall, fault;
   logic        bus_valid, bus_ready, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        resp_valid;
   logic [31:0] resp_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .byte_access (byte_access),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .stall       (stall),
      .fault       (fault),
      .bus_valid   (bus_valid),
      .bus_ready   (bus_ready),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_be      (bus_be),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata)
   );

   typedef struct {
      logic        rd, wr, bt;
      logic [31:0] a, wd, rsp;
      int          rdy, rsp_dly;
      logic [31:0] e_rdata;
      logic        e_fault, e_valid;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic        e_we;
      logic [31:0] e_wdata;
      int          e_stall;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; byte_access = 1'b0;
      addr = '0; wdata = '0;
      bus_ready = 1'b0; resp_valid = 1'b0; resp_rdata = $urandom;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Plays core and bus slave for one access; returns at posedge+1 in the following IDLE cycle.
   task automatic do_access(input vec_t v, output int st_cyc, output logic [31:0] r_rdata,
                            output logic r_fault, output logic r_valid, output logic [31:0] r_addr,
                            output logic [31:0] r_wdata, output logic [3:0] r_be, output logic r_we,
                            output logic r_to);
      int  req_i, rsp_i;
      bit  in_resp, done, hs;
      st_cyc = 0; r_rdata = '0; r_fault = 1'b0; r_valid = 1'b0; r_addr = '0;
      r_wdata = '0; r_be = '0; r_we = 1'b0; r_to = 1'b0;
      req_i = 0; rsp_i = 0; in_resp = 0; done = 0;
      mem_read = v.rd; mem_write = v.wr; byte_access = v.bt; addr = v.a; wdata = v.wd;
      for (int c = 0; c < 300 && !done; c++) begin
         bus_ready = 1'b0; resp_valid = 1'b0; resp_rdata = $urandom;
         if (bus_valid) begin
            r_valid = 1'b1; r_addr = bus_addr; r_wdata = bus_wdata; r_be = bus_be; r_we = bus_we;
            bus_ready = (req_i == v.rdy);
            req_i++;
         end else if (in_resp) begin
            resp_valid = (rsp_i == v.rsp_dly);
            if (resp_valid) resp_rdata = v.rsp;
            rsp_i++;
         end
         #1;
         if (stall) st_cyc++;
         else begin
            done = 1; r_rdata = rdata; r_fault = fault;
         end
         if (!done) begin
            hs = bus_valid && bus_ready;
            in_resp = hs || (in_resp && !resp_valid);
            @(posedge clk); #1;
         end
      end
      if (!done) r_to = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; bus_ready = 1'b0; resp_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int st; logic [31:0] rd_v, ad_v, wd_v; logic f_v, val_v, we_v, to_v; logic [3:0] be_v;
      do_access(v, st, rd_v, f_v, val_v, ad_v, wd_v, be_v, we_v, to_v);
      chk({tag, "_timeout"}, {31'd0, to_v}, 32'd0);
      chk({tag, "_stall"}, st, v.e_stall);
      chk({tag, "_rdata"}, rd_v, v.e_rdata);
      chk({tag, "_fault"}, {31'd0, f_v}, {31'd0, v.e_fault});
      chk({tag, "_valid"}, {31'd0, val_v}, {31'd0, v.e_valid});
      if (v.e_valid) begin
         chk({tag, "_addr"}, ad_v, v.e_addr);
         chk({tag, "_be"}, {28'd0, be_v}, {28'd0, v.e_be});
         chk({tag, "_we"}, {31'd0, we_v}, {31'd0, v.e_we});
         if (v.e_we) chk({tag, "_wdata"}, wd_v, v.e_wdata);
      end
   endtask

   // Reference: expected results straight from the access rules.
   function automatic vec_t model(input vec_t v, inout logic [31:0] last_rdata);
      vec_t   e = v;
      int     lane = int'(v.a % 4);
      logic   mis = !v.bt && (lane != 0);
      e.e_fault = mis;
      e.e_valid = !mis;
      e.e_stall = mis ? 1 : 3 + v.rdy + v.rsp_dly;
      e.e_addr  = v.a - lane;
      e.e_we    = v.wr;
      e.e_be    = v.bt ? 4'(1 << lane) : 4'hF;
      e.e_wdata = v.bt ? (v.wd % 256) * 32'h01010101 : v.wd;
      if (mis) last_rdata = 0;
      else if (!v.wr) last_rdata = v.bt ? (v.rsp / (32'd1 << (8 * lane))) % 256 : v.rsp;
      e.e_rdata = last_rdata;
      return e;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[6];
      vec_t        rv;
      logic [31:0] mrd;
      int          vcnt;
      bit          seen;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1'b0, 1'b1, 32'h100, 4'hF,    1'b0, 32'h0,        3};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h103, 32'h12345678, 32'h0,        0, 0, 32'hDEADBEEF, 1'b0, 1'b1, 32'h100, 4'b1000, 1'b1, 32'h78787878, 3};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h202, 32'h0,        32'hAABBCCDD, 2, 0, 32'h000000BB, 1'b0, 1'b1, 32'h200, 4'b0100, 1'b0, 32'h0,        5};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h101, 32'h0,        32'h0,        0, 0, 32'h0,        1'b1, 1'b0, 32'h0,   4'h0,    1'b0, 32'h0,        1};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0,        1, 1, 32'h0,        1'b0, 1'b1, 32'h300, 4'hF,    1'b1, 32'hCAFEF00D, 5};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h003, 32'h0,        32'h11223344, 0, 3, 32'h00000011, 1'b0, 1'b1, 32'h0,   4'b1000, 1'b0, 32'h0,        6};

      do_reset();
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
      chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_bus_be", {28'd0, bus_be}, 32'd0);

      for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      do_reset();
      mrd = 32'h0;
      for (int i = 0; i < 60; i++) begin
         int kind = $urandom_range(0, 2);
         rv.rd = (kind != 1); rv.wr = (kind != 0);
         rv.bt = $urandom_range(0, 1);
         rv.a  = $urandom;
         if (!rv.bt && $urandom_range(0, 9) < 7) rv.a[1:0] = 2'b00;
         rv.wd = $urandom; rv.rsp = $urandom;
         rv.rdy = $urandom_range(0, 3); rv.rsp_dly = $urandom_range(0, 3);
         rv = model(rv, mrd);
         run_vec(rv, $sformatf("rnd%0d", i));
      end

      // reset while waiting for the response, then a stale response in IDLE
      mem_read = 1'b1; byte_access = 1'b0; addr = 32'h80;
      @(posedge clk); #1 bus_ready = 1'b1;
      @(posedge clk); #1 bus_ready = 1'b0;
      chk("rstmid_stall_resp", {31'd0, stall}, 32'd1);
      reset = 1'b1; mem_read = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      resp_valid = 1'b1; resp_rdata = 32'h55AA55AA;
      #1;
      chk("rstmid_stall", {31'd0, stall}, 32'd0);
      chk("rstmid_bus_valid", {31'd0, bus_valid}, 32'd0);
      @(posedge clk); #1 resp_valid = 1'b0;
      chk("rstmid_rdata", rdata, 32'h0);
      chk("rstmid_fault", {31'd0, fault}, 32'd0);
      chk("rstmid_stall_after", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("rstmid_rdata_after", rdata, 32'h0);
      chk("rstmid_valid_after", {31'd0, bus_valid}, 32'd0);

      // bus that never accepts the request
      mem_read = 1'b1; byte_access = 1'b0; addr = 32'h40;
`ifdef LSU_TIMEOUT_EN
      vcnt = 0; seen = 0;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (bus_valid) vcnt++;
         else if (vcnt > 0) begin
            seen = 1;
            chk("tmo_fault", {31'd0, fault}, 32'd1);
            chk("tmo_rdata", rdata, 32'h0);
            chk("tmo_stall", {31'd0, stall}, 32'd0);
            break;
         end
         @(posedge clk);
      end
      chk("tmo_seen", {31'd0, seen}, 32'd1);
      chk("tmo_req_cycles", vcnt, 32'd16);
      mem_read = 1'b0;
      @(posedge clk); #1;
`else
      vcnt = 0; seen = 0;
      repeat (100) @(posedge clk);
      #1;
      chk("hang_stall", {31'd0, stall}, 32'd1);
      chk("hang_bus_valid", {31'd0, bus_valid}, 32'd1);
      chk("hang_fault", {31'd0, fault}, 32'd0);
      do_reset();
`endif
      chk("end_stall", {31'd0, stall}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
